// File: rtl/arith_sched_if.sv
// Bus bundle for arith_sched: two requester channels and one response channel.
//   req0_* / req1_* : valid/ready handshake carrying op (3 bits) and operands a, b (W bits)
//   rsp_*           : valid/ready handshake carrying id (1 bit), result (2W bits), err (1 bit)
// master : the environment side (operand producers + result consumer)
// slave  : the scheduler side
interface arith_sched_if #(
  parameter int W = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [2:0]     req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [2:0]     req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*W-1:0] rsp_result;
  logic           rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/arith_sched.sv
// arith_sched: one shared arithmetic unit (ADD/SUB/MUL/DIV/MOD, W-bit unsigned operands)
// time-shared between two requesters with round-robin arbitration. ADD/SUB/MUL finish in
// one execute cycle; DIV/MOD use a restoring divider producing one quotient bit per cycle.
// Only one operation is in flight at a time; requests are accepted only while idle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arith_sched_if slave modport (req0_*, req1_*, rsp_*)
module arith_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  arith_sched_if.slave bus
);

  localparam int RW    = 2 * W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIVI = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             ptr;
  logic             gnt_any;
  logic             gnt_id;

  logic [2:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             id_q;

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     step_rem;
  logic [W-1:0]     step_quo;

  logic             rsp_id_q;
  logic [RW-1:0]    rsp_result_q;
  logic             rsp_err_q;

  logic             is_divmod;
  logic             exec_err;
  logic             exec_div;
  logic             div_last;

  // Single-cycle ops; SUB wraps to W bits with the upper half left at zero.
  function automatic logic [RW-1:0] fast_result(input logic [2:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic [RW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = RW'(a) + RW'(b);
      OP_SUB:  r[W-1:0] = a - b;
      OP_MUL:  r = RW'(a) * RW'(b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // One restoring-division step: shift the next dividend bit (MSB of quo) into the
  // partial remainder, subtract the divisor when it fits and record the quotient bit.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] dvs);
    logic [W:0]   sh;
    logic [W-1:0] q;
    sh = {rem, quo[W-1]};
    q  = quo << 1;
    if (sh >= {1'b0, dvs}) begin
      sh   = sh - {1'b0, dvs};
      q[0] = 1'b1;
    end
    return {sh[W-1:0], q};
  endfunction

  assign is_divmod = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign exec_err  = (op_q > OP_MOD) || (is_divmod && (b_q == '0));
  assign exec_div  = is_divmod && (b_q != '0);
  assign div_last  = (cnt_q == CNT_W'(W - 1));

  always_comb begin
    {step_rem, step_quo} = div_step(rem_q, quo_q, b_q);
  end

  // Arbitration: a lone requester wins; on contention the pointer decides. Ready is
  // only offered while idle and is forced low while reset is asserted.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ptr;
      end else if (bus.req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = gnt_any && !gnt_id;
  assign bus.req1_ready = gnt_any &&  gnt_id;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_any) state_nxt = EXEC;
      EXEC: state_nxt = exec_div ? DIVI : RESP;
      DIVI: if (div_last) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_any) ptr <= ~gnt_id;
    end
  end

  // Accept stage: capture the granted request
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      id_q <= gnt_id;
      op_q <= gnt_id ? bus.req1_op : bus.req0_op;
      a_q  <= gnt_id ? bus.req1_a  : bus.req0_a;
      b_q  <= gnt_id ? bus.req1_b  : bus.req0_b;
    end
  end

  // Divider stage: EXEC seeds the dividend, DIVI iterates W times MSB first
  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      rem_q <= '0;
      quo_q <= a_q;
      cnt_q <= '0;
    end else if (state == DIVI) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response stage: registers stay untouched in RESP so the consumer sees stable data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id_q <= id_q;
      if (exec_err) begin
        rsp_result_q <= '1;
        rsp_err_q    <= 1'b1;
      end else if (!exec_div) begin
        rsp_result_q <= fast_result(op_q, a_q, b_q);
        rsp_err_q    <= 1'b0;
      end
    end else if (state == DIVI && div_last) begin
      rsp_result_q <= RW'((op_q == OP_DIV) ? step_quo : step_rem);
      rsp_err_q    <= 1'b0;
    end
  end

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_arith_sched.sv
// Scoreboard bench for arith_sched (W=4): drivers issue requests, a negedge monitor
// predicts grants with a round-robin model, pushes expected responses computed with
// plain arithmetic, and pops/compares when the DUT presents a response.
module tb_arith_sched;
  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  arith_sched_if #(.W(W)) bus ();

  arith_sched #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit id;
    int res;
    bit err;
    int acc_cyc;
    int lat;
  } exp_t;

  exp_t sbq[$];
  bit   busy      = 0;
  bit   mptr      = 0;
  bit   presented = 0;
  bit   snap_id;
  int   snap_res;
  bit   snap_err;
  bit   rr_en     = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output bit err, output int lat);
    err = 0;
    lat = 2;
    res = 0;
    case (op)
      0: res = a + b;
      1: res = (a + (1 << W) - b) % (1 << W);
      2: res = a * b;
      3, 4: begin
        if (b == 0) begin
          res = (1 << RW) - 1;
          err = 1;
        end else begin
          res = (op == 3) ? a / b : a % b;
          lat = W + 2;
        end
      end
      default: begin
        res = (1 << RW) - 1;
        err = 1;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      presented = 0;
    end else begin
      bit   a0, a1, exp_id;
      exp_t e;
      int   op, a, b;
      if (busy) begin
        chk("ready_while_busy", int'(bus.req0_ready | bus.req1_ready), 0);
      end
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      if (a0 || a1) begin
        exp_id = (bus.req0_valid && bus.req1_valid) ? mptr : !bus.req0_valid;
        chk("grant", int'({a0, a1}), exp_id ? 1 : 2);
        op = a1 ? int'(bus.req1_op) : int'(bus.req0_op);
        a  = a1 ? int'(bus.req1_a)  : int'(bus.req0_a);
        b  = a1 ? int'(bus.req1_b)  : int'(bus.req0_b);
        e.id      = a1;
        e.acc_cyc = cyc;
        model(op, a, b, e.res, e.err, e.lat);
        sbq.push_back(e);
        mptr = !a1;
        busy = 1;
      end
      if (bus.rsp_valid) begin
        if (!presented) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("rsp_id", int'(bus.rsp_id), int'(e.id));
            chk("rsp_result", int'(bus.rsp_result), e.res);
            chk("rsp_err", int'(bus.rsp_err), int'(e.err));
            chk("rsp_latency", cyc - e.acc_cyc, e.lat);
          end
          snap_id   = bus.rsp_id;
          snap_res  = int'(bus.rsp_result);
          snap_err  = bus.rsp_err;
          presented = 1;
        end else begin
          chk("hold_id", int'(bus.rsp_id), int'(snap_id));
          chk("hold_result", int'(bus.rsp_result), snap_res);
          chk("hold_err", int'(bus.rsp_err), int'(snap_err));
        end
        if (bus.rsp_ready) begin
          presented = 0;
          busy      = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rr_en) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive(input int port, input int op, input int a, input int b);
    bit done;
    done = 0;
    if (port == 0) begin
      bus.req0_op = 3'(op); bus.req0_a = W'(a); bus.req0_b = W'(b); bus.req0_valid = 1'b1;
    end else begin
      bus.req1_op = 3'(op); bus.req1_a = W'(a); bus.req1_b = W'(b); bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (port == 0) done = bus.req0_valid && bus.req0_ready;
      else           done = bus.req1_valid && bus.req1_ready;
    end
    if (done) begin
      @(posedge clk);
      #2;
    end else begin
      chk("accept_timeout", port, -1);
    end
    if (port == 0) bus.req0_valid = 1'b0;
    else           bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      #3;
      ok = !busy && (sbq.size() == 0);
    end
    if (!ok) chk("idle_timeout", sbq.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_result", int'(bus.rsp_result), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);
    chk("rst_req0_ready", int'(bus.req0_ready), 0);
    chk("rst_req1_ready", int'(bus.req1_ready), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    sbq.delete();
    busy = 0;
    mptr = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_op    = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op    = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
    #13;
    chk_reset_outputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Directed single operations
    drive(0, 0, 3, 4);   wait_idle();
    drive(0, 0, 15, 15); wait_idle();
    drive(1, 1, 3, 4);   wait_idle();
    drive(1, 2, 3, 4);   wait_idle();
    drive(1, 2, 15, 15); wait_idle();
    drive(0, 3, 3, 2);   wait_idle();
    drive(0, 4, 3, 2);   wait_idle();
    drive(0, 3, 7, 0);   wait_idle();
    drive(1, 6, 5, 5);   wait_idle();
    drive(1, 4, 15, 1);  wait_idle();
    drive(0, 3, 15, 15); wait_idle();

    // Both requesters busy from reset: grants must alternate
    do_reset();
    @(posedge clk);
    #2;
    fork
      for (int i = 0; i < 4; i++) drive(0, 0, i, 1);
      for (int j = 0; j < 4; j++) drive(1, 2, j, 3);
    join
    wait_idle();

    // req1 alone, then contention: req0 must win
    drive(1, 1, 9, 2);
    wait_idle();
    fork
      drive(0, 0, 1, 1);
      drive(1, 0, 2, 2);
    join
    wait_idle();

    // Back-pressure: response held while rsp_ready is low; a transient request is ignored
    bus.rsp_ready = 1'b0;
    drive(0, 2, 5, 7);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk);
        #3;
        seen = bus.rsp_valid;
      end
      chk("hold_rsp_seen", int'(seen), 1);
    end
    bus.req1_op = 3'd0; bus.req1_a = 4'd1; bus.req1_b = 4'd1; bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Randomized traffic with random consumer back-pressure
    rr_en = 1;
    for (int k = 0; k < 40; k++) begin
      int mode, op0, op1, x0, y0, x1, y1;
      mode = $urandom_range(0, 2);
      op0  = $urandom_range(0, 7);
      op1  = $urandom_range(0, 7);
      x0   = $urandom_range(0, 15);
      x1   = $urandom_range(0, 15);
      y0   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
      y1   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
      if (mode == 0)      drive(0, op0, x0, y0);
      else if (mode == 1) drive(1, op1, x1, y1);
      else begin
        fork
          drive(0, op0, x0, y0);
          drive(1, op1, x1, y1);
        join
      end
    end
    wait_idle();
    rr_en = 0;
    @(posedge clk);
    #3;
    bus.rsp_ready = 1'b1;

    // Asynchronous reset during the second divider cycle drops the operation
    drive(0, 3, 13, 3);
    @(posedge clk);
    @(posedge clk);
    #3;
    do_reset();
    repeat (W + 4) begin
      @(posedge clk);
      #3;
      chk("post_reset_no_rsp", int'(bus.rsp_valid), 0);
    end
    fork
      drive(0, 0, 6, 6);
      drive(1, 0, 7, 7);
    join
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
